// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write-only master: FSM states,
// quarter-bit phase indices and the byte width.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACK,
        STOP,
        TURN
    } state_t;

    // Phase within one bit period: SCL is low in Q0/Q1 and high in Q2/Q3.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_qtick.sv
// Bit-period timebase: divides clk by QDIV into quarter-bit ticks and
// tracks the quarter index. q_end marks the last clk cycle of a quarter,
// bit_end the last clk cycle of a whole bit period.
module i2c_qtick
    import i2c_pkg::*;
#(
    parameter int QDIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    output logic [1:0] quarter,
    output logic       q_end,
    output logic       bit_end
);

    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] QLAST = CW'(QDIV - 1);

    logic [CW-1:0] qcnt;

    // Prescaler and quarter counter, held at zero while clr is high.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            qcnt    <= '0;
            quarter <= Q0;
        end else if (qcnt == QLAST) begin
            qcnt    <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            qcnt <= qcnt + CW'(1);
        end
    end

    assign q_end   = (qcnt == QLAST);
    assign bit_end = q_end && (quarter == Q3);

endmodule

// File: rtl/i2c_master_wr.sv
// I2C write-only master: sends NBYTES bytes (address first, MSB first) per
// wr_i2c request, aborts on NACK and reports done/NACK status.
// SCL and SDA are registered and updated one cycle ahead of each quarter,
// so the bus always shows the phase the quarter counter is in.
// Optional feature macro: I2C_RETRY_EN (restart a NACKed transaction up to
// MAX_RETRY times before reporting it).
module i2c_master_wr
    import i2c_pkg::*;
#(
    parameter int NBYTES    = 3,
    parameter int QDIV      = 125,
    parameter int MAX_RETRY = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [BITS_PER_BYTE*NBYTES-1:0] din,
    input  logic                            wr_i2c,
    output logic                            i2c_idle,
    output logic                            i2c_done,
    output logic                            i2c_nack,
    output logic                            i2c_sclk,
    inout  wire                             i2c_sdat
);

    localparam int BW  = BITS_PER_BYTE * NBYTES;
    localparam int BYW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BYW-1:0] LAST_BYTE = BYW'(NBYTES - 1);

    if (NBYTES < 1 || QDIV < 1 || MAX_RETRY < 0) begin : g_param_check
        $error("i2c_master_wr: NBYTES and QDIV must be >= 1, MAX_RETRY >= 0");
    end

    state_t          state;
    logic [BW-1:0]   sreg;
    logic [3:0]      bit_idx;
    logic [BYW-1:0]  byte_idx;
    logic            failed;
    logic            sda_lo;
    logic [1:0]      quarter;
    logic            q_end;
    logic            bit_end;

`ifdef I2C_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [BW-1:0]   retry_data;
    logic [RW-1:0]   retry_cnt;
`endif

    i2c_qtick #(.QDIV(QDIV)) u_qtick (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == IDLE),
        .quarter (quarter),
        .q_end   (q_end),
        .bit_end (bit_end)
    );

    // Open drain: SDA is only ever pulled low or released.
    assign i2c_sdat = sda_lo ? 1'b0 : 1'bz;

    // Transaction FSM; bus outputs are loaded with the value for the next quarter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            sreg     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            failed   <= 1'b0;
            sda_lo   <= 1'b0;
            i2c_sclk <= 1'b1;
            i2c_idle <= 1'b1;
            i2c_done <= 1'b0;
            i2c_nack <= 1'b0;
`ifdef I2C_RETRY_EN
            retry_data <= '0;
            retry_cnt  <= '0;
`endif
        end else begin
            i2c_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_i2c) begin
                        state    <= START;
                        sreg     <= din;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        failed   <= 1'b0;
                        i2c_idle <= 1'b0;
                        i2c_nack <= 1'b0;
`ifdef I2C_RETRY_EN
                        retry_data <= din;
                        retry_cnt  <= '0;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        i2c_sclk <= 1'b0;
                        sda_lo   <= ~sreg[BW-1];
                    end else if (q_end) begin
                        sda_lo <= (quarter >= Q1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        i2c_sclk <= 1'b0;
                        sreg     <= {sreg[BW-2:0], 1'b0};
                        if (bit_idx == 4'(BITS_PER_BYTE - 1)) begin
                            state   <= ACK;
                            bit_idx <= 4'(BITS_PER_BYTE);
                            sda_lo  <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            sda_lo  <= ~sreg[BW-2];
                        end
                    end else if (q_end) begin
                        i2c_sclk <= (quarter >= Q1);
                    end
                end
                ACK: begin
                    if (bit_end) begin
                        i2c_sclk <= 1'b0;
                        if (failed || byte_idx == LAST_BYTE) begin
                            state  <= STOP;
                            sda_lo <= 1'b1;
                        end else begin
                            state    <= DATA;
                            byte_idx <= byte_idx + BYW'(1);
                            bit_idx  <= '0;
                            sda_lo   <= ~sreg[BW-1];
                        end
                    end else if (q_end) begin
                        i2c_sclk <= (quarter >= Q1);
                        // Sample the slave at the end of the first SCL-high quarter.
                        if (quarter == Q2) begin
                            failed <= i2c_sdat;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state    <= TURN;
                        i2c_sclk <= 1'b1;
                        sda_lo   <= 1'b0;
                    end else if (q_end) begin
                        i2c_sclk <= (quarter >= Q1);
                        sda_lo   <= (quarter != Q2);
                    end
                end
                TURN: begin
                    if (bit_end) begin
`ifdef I2C_RETRY_EN
                        if (failed && retry_cnt < RW'(MAX_RETRY)) begin
                            state     <= START;
                            sreg      <= retry_data;
                            retry_cnt <= retry_cnt + RW'(1);
                            failed    <= 1'b0;
                            bit_idx   <= '0;
                            byte_idx  <= '0;
                        end else
`endif
                        begin
                            state    <= IDLE;
                            i2c_idle <= 1'b1;
                            i2c_done <= 1'b1;
                            i2c_nack <= failed;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: a clk-sampled I2C slave model decodes the bus,
// drives ACK/NACK, and counts START/STOP/SCL events. Table rows cover full
// and aborted transactions; hand sequences cover reset, ignored requests,
// back-to-back requests and (with I2C_RETRY_EN) retries.
module tb_i2c_master_wr;

    localparam int NBYTES     = 3;
    localparam int QDIV       = 2;
    localparam int MAX_RETRY  = 3;
    localparam int BIT_CYC    = 4 * QDIV;
    localparam int TXN_BUDGET = 2000;

    logic                clk     = 1'b0;
    logic                reset   = 1'b0;
    logic [8*NBYTES-1:0] din     = '0;
    logic                wr_i2c  = 1'b0;
    logic                i2c_idle;
    logic                i2c_done;
    logic                i2c_nack;
    logic                i2c_sclk;
    wire                 i2c_sdat;
    logic                slave_lo = 1'b0;

    assign i2c_sdat = slave_lo ? 1'b0 : 1'bz;
    pullup (i2c_sdat);

    i2c_master_wr #(
        .NBYTES    (NBYTES),
        .QDIV      (QDIV),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .wr_i2c   (wr_i2c),
        .i2c_idle (i2c_idle),
        .i2c_done (i2c_done),
        .i2c_nack (i2c_nack),
        .i2c_sclk (i2c_sclk),
        .i2c_sdat (i2c_sdat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model state (written only by the monitor below)
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bit_cnt  = 0;
    int         txn_byte = 0;
    logic [7:0] rx_sh    = '0;
    logic [7:0] rx_q[$];
    int start_cnt = 0, stop_cnt = 0, rise_cnt = 0, done_cnt = 0;
    int nack_given = 0;
    int last_start_cyc = 0, last_stop_cyc = 0;
    // Written only by the stimulus: NACK address bytes while nack_given < nack_plan
    int nack_plan = 0;

    // Bus sampled mid-cycle; the DUT only moves its lines on rising clk edges.
    always @(negedge clk) begin
        logic s, d;
        s = (i2c_sclk === 1'b1);
        d = (i2c_sdat === 1'b0) ? 1'b0 : 1'b1;
        if (i2c_done === 1'b1) done_cnt++;
        if (prev_scl && s) begin
            if (prev_sda && !d) begin
                start_cnt++;
                last_start_cyc = cyc;
                bit_cnt = 0;
                txn_byte = 0;
            end
            if (!prev_sda && d) begin
                stop_cnt++;
                last_stop_cyc = cyc;
            end
        end
        if (!prev_scl && s) begin
            rise_cnt++;
            if (bit_cnt < 8) begin
                rx_sh = {rx_sh[6:0], d};
                bit_cnt++;
                if (bit_cnt == 8) rx_q.push_back(rx_sh);
            end else begin
                bit_cnt = 0;
            end
        end
        if (prev_scl && !s) begin
            if (bit_cnt == 8) begin
                if (txn_byte == 0 && nack_given < nack_plan) begin
                    nack_given++;
                    slave_lo = 1'b0;
                end else begin
                    slave_lo = 1'b1;
                end
                txn_byte++;
            end else begin
                slave_lo = 1'b0;
            end
        end
        prev_scl = s;
        prev_sda = d;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One-cycle request; returns the cycle stamp taken just after acceptance.
    task automatic pulse_req(input logic [8*NBYTES-1:0] data, output int t_acc);
        @(negedge clk);
        din    = data;
        wr_i2c = 1'b1;
        @(negedge clk);
        wr_i2c = 1'b0;
        t_acc  = cyc;
    endtask

    task automatic wait_done(input int t_acc, output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int i = 0; i < TXN_BUDGET && !seen; i++) begin
            @(negedge clk);
            if (i2c_done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - t_acc;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [23:0] data;
        int          nacks;
        int          exp_lat;
        logic        exp_nack;
        int          exp_cnt;
        int          exp_chk;
        int          exp_starts;
        int          exp_rises;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int t0, lat, stop1;
        int base_rx, base_st, base_sp, base_rise, base_done;

        vecs[0] = '{24'h341E00, 0, 240, 1'b0, 3, 3, 1, 28};
        vecs[1] = '{24'hA55AFF, 0, 240, 1'b0, 3, 3, 1, 28};
        vecs[2] = '{24'h80017E, 0, 240, 1'b0, 3, 3, 1, 28};
`ifdef I2C_RETRY_EN
        vecs[3] = '{24'h341E00, 4, 384, 1'b1, 4, 1, 4, 40};
`else
        vecs[3] = '{24'h341E00, 1, 96, 1'b1, 1, 1, 1, 10};
`endif

        // Reset values, during and just after reset
        repeat (3) @(negedge clk);
        check("rst_idle", i2c_idle, 1);
        check("rst_done", i2c_done, 0);
        check("rst_nack", i2c_nack, 0);
        check("rst_scl", i2c_sclk, 1);
        check("rst_sda", i2c_sdat, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", i2c_idle, 1);
        check("post_rst_scl", i2c_sclk, 1);

        // Table-driven transactions
        for (int v = 0; v < 4; v++) begin
            base_rx   = rx_q.size();
            base_st   = start_cnt;
            base_sp   = stop_cnt;
            base_rise = rise_cnt;
            base_done = done_cnt;
            nack_plan = nack_given + vecs[v].nacks;
            pulse_req(vecs[v].data, t0);
            check($sformatf("v%0d_idle_fall", v), i2c_idle, 0);
            wait_done(t0, lat);
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_nack", v), i2c_nack, vecs[v].exp_nack);
            check($sformatf("v%0d_idle_back", v), i2c_idle, 1);
            repeat (3 * BIT_CYC) @(negedge clk);
            check($sformatf("v%0d_rx_count", v), rx_q.size() - base_rx, vecs[v].exp_cnt);
            for (int b = 0; b < vecs[v].exp_chk; b++)
                check($sformatf("v%0d_rx_byte%0d", v, b), rx_q[base_rx + b],
                      vecs[v].data[8*(NBYTES-1-b) +: 8]);
            check($sformatf("v%0d_starts", v), start_cnt - base_st, vecs[v].exp_starts);
            check($sformatf("v%0d_stops", v), stop_cnt - base_sp, vecs[v].exp_starts);
            check($sformatf("v%0d_scl_rises", v), rise_cnt - base_rise, vecs[v].exp_rises);
            check($sformatf("v%0d_done_pulses", v), done_cnt - base_done, 1);
            check($sformatf("v%0d_nack_held", v), i2c_nack, vecs[v].exp_nack);
        end

        // Reset during DATA of byte 1, then a clean transaction
        nack_plan = nack_given;
        pulse_req(24'hC35A96, t0);
        repeat (100) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_scl", i2c_sclk, 1);
        check("midrst_sda", i2c_sdat, 1);
        check("midrst_idle", i2c_idle, 1);
        check("midrst_done", i2c_done, 0);
        check("midrst_nack", i2c_nack, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        base_rx = rx_q.size();
        pulse_req(24'h341E00, t0);
        wait_done(t0, lat);
        check("after_rst_latency", lat, 240);
        check("after_rst_nack", i2c_nack, 0);
        repeat (BIT_CYC) @(negedge clk);
        check("after_rst_rx_count", rx_q.size() - base_rx, 3);
        check("after_rst_byte0", rx_q[base_rx], 8'h34);
        check("after_rst_byte2", rx_q[base_rx + 2], 8'h00);

        // Request while busy must be ignored
        base_rx = rx_q.size();
        base_st = start_cnt;
        pulse_req(24'h123456, t0);
        repeat (50) @(negedge clk);
        din    = 24'hFFFFFF;
        wr_i2c = 1'b1;
        @(negedge clk);
        wr_i2c = 1'b0;
        din    = '0;
        wait_done(t0, lat);
        check("busy_req_latency", lat, 240);
        repeat (3 * BIT_CYC) @(negedge clk);
        check("busy_req_rx_count", rx_q.size() - base_rx, 3);
        check("busy_req_byte0", rx_q[base_rx], 8'h12);
        check("busy_req_byte1", rx_q[base_rx + 1], 8'h34);
        check("busy_req_byte2", rx_q[base_rx + 2], 8'h56);
        check("busy_req_starts", start_cnt - base_st, 1);
        check("busy_req_idle", i2c_idle, 1);

        // Back-to-back: request presented in the i2c_done cycle
        base_rx   = rx_q.size();
        base_done = done_cnt;
        pulse_req(24'h341E00, t0);
        wait_done(t0, lat);
        check("b2b_first_latency", lat, 240);
        stop1  = last_stop_cyc;
        din    = 24'h5AC30F;
        wr_i2c = 1'b1;
        @(negedge clk);
        wr_i2c = 1'b0;
        t0     = cyc;
        check("b2b_accept", i2c_idle, 0);
        wait_done(t0, lat);
        check("b2b_second_latency", lat, 240);
        check("b2b_turn_gap", (last_start_cyc - stop1) >= BIT_CYC, 1);
        repeat (BIT_CYC) @(negedge clk);
        check("b2b_rx_count", rx_q.size() - base_rx, 6);
        check("b2b_byte3", rx_q[base_rx + 3], 8'h5A);
        check("b2b_byte4", rx_q[base_rx + 4], 8'hC3);
        check("b2b_byte5", rx_q[base_rx + 5], 8'h0F);
        check("b2b_done_pulses", done_cnt - base_done, 2);

`ifdef I2C_RETRY_EN
        // Two NACKs then success: three STARTs, one done, no NACK reported
        base_st   = start_cnt;
        base_done = done_cnt;
        nack_plan = nack_given + 2;
        pulse_req(24'h341E00, t0);
        repeat (100) @(negedge clk);
        check("retry_idle_low", i2c_idle, 0);
        wait_done(t0, lat);
        check("retry_latency", lat, 432);
        check("retry_nack", i2c_nack, 0);
        repeat (BIT_CYC) @(negedge clk);
        check("retry_starts", start_cnt - base_st, 3);
        check("retry_done_pulses", done_cnt - base_done, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_master_wr.md
# i2c_master_wr

Parametrised I2C write-only master for codec register configuration; generalises the fixed 3-byte controller to N bytes per transaction with programmable bit rate, NACK reporting and an optional automatic retry. Accepts one transaction per `wr_i2c` pulse, drives open-drain SDA and push-pull SCL, and reports completion and acknowledge status to the configuration sequencer above it.

## Interface
- `NBYTES`, 3: bytes per transaction (slave address plus payload), ≥1.
- `QDIV`, 125: `clk` cycles per quarter bit period, ≥1. SCL = f_clk/(4·QDIV).
- `MAX_RETRY`, 3: retry attempts after NACK; used only with `I2C_RETRY_EN`.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `din`  in  8·NBYTES  transaction bytes; byte 0 is `din[8·NBYTES-1 -: 8]`, sent first, MSB first.
- `wr_i2c`  in  1  start request; honoured only while `i2c_idle`=1.
- `i2c_idle`  out  1  high when ready to accept a request.
- `i2c_done`  out  1  one-cycle pulse when a transaction ends (ACKed or aborted).
- `i2c_nack`  out  1  status of last transaction: 1 = a NACK aborted it; valid from `i2c_done`, held until next accepted request.
- `i2c_sclk`  out  1  SCL.
- `i2c_sdat`  inout  1  SDA; driven 0 or high-Z only, never 1.

## Operation
- States: IDLE, START, DATA, ACK, STOP, TURN.
- Bit period = 4 quarters q0..q3, each QDIV cycles. In DATA/ACK: SCL low in q0–q1, high in q2–q3; SDA changes only at q0 start.
- IDLE: SCL=1, SDA released, `i2c_idle`=1. `wr_i2c`=1 with `i2c_idle`=1 latches `din` into a shift register, clears `i2c_nack`, enters START. Requests while not idle are ignored.
- START (1 bit period): SDA released q0–q1, driven low from q2; SCL high throughout.
- DATA (8 bit periods per byte): SDA = shift-register MSB; shift left at each bit boundary.
- ACK (1 bit period): SDA released; sample `i2c_sdat` on the last cycle of q2. 0 → next byte in DATA, or STOP after byte NBYTES-1. 1 → set `i2c_nack`, go STOP (abort).
- STOP (1 bit period): SDA low q0–q2 with SCL low q0–q1, high q2–q3; SDA released at q3 start.
- TURN (1 bit period): both lines high (bus-free time); then IDLE with `i2c_done` pulsed on the entry cycle.
- Counters: quarter-cycle counter width clog2(QDIV), quarter index 2 bits, bit index 0..8, byte index clog2(NBYTES); all clear on START entry.

## Timing
- Reset values: state IDLE, `i2c_sclk`=1, `i2c_sdat`=Z, `i2c_idle`=1, `i2c_done`=0, `i2c_nack`=0, counters 0.
- `i2c_idle` falls the cycle after `wr_i2c` is sampled; START q0 begins that same cycle.
- Full ACKed transaction: (9·NBYTES+3) bit periods = 4·QDIV·(9·NBYTES+3) cycles from acceptance to `i2c_done`.
- Aborted at byte k ACK: STOP follows that ACK immediately; length 4·QDIV·(9·(k+1)+3).
- `wr_i2c` coincident with `i2c_done`: accepted (`i2c_idle` already 1 that cycle).
- Reset asserted mid-transaction: next edge returns to reset values; SDA/SCL released with no STOP. The sequencer re-issues the transaction.
- `din` is not sampled after acceptance; it may change freely.

## Configuration
- `I2C_RETRY_EN` defined: on NACK, after STOP+TURN, restart from START with the latched data. Allows up to MAX_RETRY retries. `i2c_done` pulses only once, after success or after the last failed retry. `i2c_nack`=1 only if all retries failed. `i2c_idle` stays 0 throughout.
- Undefined: no retry, no retry counter; NACK ends the transaction as described.

## Structure
- Package `i2c_pkg`: state enum, quarter indices Q0..Q3, bits-per-byte constant 8.
- Sub-module `i2c_qtick`: QDIV prescaler plus 2-bit quarter counter. Outputs quarter index and end-of-quarter/end-of-bit strobes. Synchronous clear from the FSM.

## Test plan
- NBYTES=3, QDIV=2, din=24'h34_1E_00, slave model ACKs all: bytes 34,1E,00 decoded on SCL rising edges. START/STOP observed. `i2c_done` exactly 240 cycles after acceptance, `i2c_nack`=0.
- Slave NACKs address byte (retry off): STOP after first ACK slot. `i2c_done` at 4·2·12=96 cycles, `i2c_nack`=1, no further SCL pulses.
- `wr_i2c` pulsed mid-transaction with different `din`: ignored; bus carries only the original bytes.
- Reset low during DATA of byte 1: next cycle SCL=1, SDA=Z, `i2c_idle`=1; new request then completes normally.
- `wr_i2c` held on the `i2c_done` cycle: back-to-back transaction; TURN gap between STOP and next START ≥1 bit period.
- With `I2C_RETRY_EN`, MAX_RETRY=3, slave NACKs twice then ACKs: 3 STARTs observed, single `i2c_done`, `i2c_nack`=0.
